// File: rtl/vend_pkg.sv
// Types and constants shared by the vending-machine controller and the change dispenser.
package vend_pkg;

  typedef logic [7:0] amount_t;

  localparam logic [5:0] COIN_50 = 6'd50;
  localparam logic [5:0] COIN_10 = 6'd10;
  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_1  = 6'd1;

  // Index order doubles as payout priority: lower index is the larger coin.
  typedef enum logic [1:0] {
    D50 = 2'd0,
    D10 = 2'd1,
    D5  = 2'd2,
    D1  = 2'd3
  } denom_e;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StIssue,
    StDone
  } state_e;

  function automatic logic [5:0] coin_of(denom_e d);
    logic [5:0] v;
    unique case (d)
      D50:     v = COIN_50;
      D10:     v = COIN_10;
      D5:      v = COIN_5;
      default: v = COIN_1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy picker: largest denomination that fits the remaining amount and is still in stock.
module change_coin_select
  import vend_pkg::*;
(
  input  amount_t    remaining,
  input  logic [3:0] stock_nz,
  output denom_e     denom,
  output logic       found
);

  always_comb begin
    denom = D1;
    found = 1'b1;
    if (remaining >= {2'b00, COIN_50} && stock_nz[3]) begin
      denom = D50;
    end else if (remaining >= {2'b00, COIN_10} && stock_nz[2]) begin
      denom = D10;
    end else if (remaining >= {2'b00, COIN_5} && stock_nz[1]) begin
      denom = D5;
    end else if (remaining >= {2'b00, COIN_1} && stock_nz[0]) begin
      denom = D1;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time, greedy largest-first, with per-coin stock.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned INIT_STOCK = 8,
  parameter int unsigned STOCK_W    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  amount_t    change_amount,
  output logic       change_ready,
  output logic       coin_valid,
  output logic [5:0] coin_value,
  input  logic       coin_ack,
  input  logic       refill,
  output logic       done,
  output logic       short_flag,
  output amount_t    remaining,
  output logic [3:0] stock_empty
);

  localparam logic [STOCK_W-1:0] InitCnt = STOCK_W'(INIT_STOCK);

  state_e             r_state;
  state_e             w_state_next;
  logic [STOCK_W-1:0] r_stock [4];
  amount_t            r_remaining;
  logic [5:0]         r_coin_value;
  denom_e             r_denom;
  logic               r_short;

  logic [3:0] w_stock_nz;
  denom_e     w_pick;
  logic       w_found;
  logic       w_accept;
  logic       w_take;
  logic       w_refill;

  // Stock array is indexed by denom_e; status bits are ordered 50/10/5/1 from bit 3 down.
  for (genvar i = 0; i < 4; i++) begin : g_nz
    assign w_stock_nz[3-i] = (r_stock[i] != '0);
  end

  change_coin_select u_select (
    .remaining (r_remaining),
    .stock_nz  (w_stock_nz),
    .denom     (w_pick),
    .found     (w_found)
  );

  assign w_accept = (r_state == StIdle) && change_valid;
  assign w_take   = (r_state == StIssue) && coin_ack;
  assign w_refill = (r_state == StIdle) && refill && !change_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (change_valid) w_state_next = StSelect;
      StSelect: w_state_next = w_found ? StIssue : StDone;
      StIssue:  if (coin_ack) w_state_next = StSelect;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    change_ready = (r_state == StIdle);
    coin_valid   = (r_state == StIssue);
    done         = (r_state == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining  <= '0;
      r_coin_value <= '0;
      r_denom      <= D50;
      r_short      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_stock[i] <= InitCnt;
      end
    end else begin
      if (w_accept) begin
        r_remaining <= change_amount;
      end else if (w_take) begin
        r_remaining <= r_remaining - {2'b00, r_coin_value};
      end

      if (r_state == StSelect) begin
        if (w_found) begin
          r_coin_value <= coin_of(w_pick);
          r_denom      <= w_pick;
        end
        // Nothing payable: a nonzero remainder means stock ran out.
        r_short <= !w_found && (r_remaining != '0);
      end

      for (int i = 0; i < 4; i++) begin
        if (w_refill) begin
          r_stock[i] <= InitCnt;
        end else if (w_take && (int'(r_denom) == i) && (r_stock[i] != '0)) begin
          r_stock[i] <= r_stock[i] - 1'b1;
        end
      end
    end
  end

  assign coin_value  = r_coin_value;
  assign short_flag  = r_short;
  assign remaining   = r_remaining;
  assign stock_empty = ~w_stock_nz;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench: two dispensers (stock 8 and stock 2) checked against hand-computed payouts.
module tb_change_dispenser;
  import vend_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] reset, change_valid, coin_ack, refill;
  logic [1:0] change_ready, coin_valid, done, short_flag;
  amount_t    change_amount [2];
  amount_t    remaining     [2];
  logic [5:0] coin_value    [2];
  logic [3:0] stock_empty   [2];

  change_dispenser #(.INIT_STOCK(8), .STOCK_W(6)) dut0 (
    .clk(clk), .reset(reset[0]), .change_valid(change_valid[0]),
    .change_amount(change_amount[0]), .change_ready(change_ready[0]),
    .coin_valid(coin_valid[0]), .coin_value(coin_value[0]), .coin_ack(coin_ack[0]),
    .refill(refill[0]), .done(done[0]), .short_flag(short_flag[0]),
    .remaining(remaining[0]), .stock_empty(stock_empty[0])
  );

  change_dispenser #(.INIT_STOCK(2), .STOCK_W(6)) dut1 (
    .clk(clk), .reset(reset[1]), .change_valid(change_valid[1]),
    .change_amount(change_amount[1]), .change_ready(change_ready[1]),
    .coin_valid(coin_valid[1]), .coin_value(coin_value[1]), .coin_ack(coin_ack[1]),
    .refill(refill[1]), .done(done[1]), .short_flag(short_flag[1]),
    .remaining(remaining[1]), .stock_empty(stock_empty[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    bit is_done;
    int val;
    int shrt;
    int rem;
    int se;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_coin(input int k, input int v);
    exp_t e;
    e = '{is_done: 1'b0, val: v, shrt: 0, rem: 0, se: 0};
    push(k, e);
  endtask

  task automatic push_done(input int k, input int s, input int r, input int se);
    exp_t e;
    e = '{is_done: 1'b1, val: 0, shrt: s, rem: r, se: se};
    push(k, e);
  endtask

  // Monitor: a coin is consumed when offered and acked; done carries the final status.
  always @(negedge clk) begin
    exp_t e;
    bit   have, ev_coin, ev_done;
    for (int k = 0; k < 2; k++) begin
      ev_coin = coin_valid[k] && coin_ack[k] && !reset[k];
      ev_done = done[k] && !reset[k];
      if (ev_coin || ev_done) begin
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d output expected", k), int'(have), 1);
        if (have) begin
          chk($sformatf("dut%0d event kind(done)", k), int'(ev_done), int'(e.is_done));
          if (ev_coin && !e.is_done) begin
            chk($sformatf("dut%0d coin_value", k), int'(coin_value[k]), e.val);
          end else if (ev_done && e.is_done) begin
            chk($sformatf("dut%0d short", k), int'(short_flag[k]), e.shrt);
            chk($sformatf("dut%0d remaining", k), int'(remaining[k]), e.rem);
            chk($sformatf("dut%0d stock_empty", k), int'(stock_empty[k]), e.se);
          end
        end
      end
    end
  end

  task automatic request(input int k, input int amt);
    change_valid[k]  = 1'b1;
    change_amount[k] = amount_t'(amt);
    @(posedge clk); #1;
    change_valid[k]  = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[k]) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    chk($sformatf("dut%0d done within budget", k), int'(seen), 1);
  endtask

  task automatic wait_valid(input int k, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (coin_valid[k]) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("dut%0d coin offered within budget", k), int'(seen), 1);
  endtask

  initial begin
    reset         = 2'b11;
    change_valid  = 2'b00;
    coin_ack      = 2'b00;
    refill        = 2'b00;
    change_amount = '{8'd0, 8'd0};
    repeat (3) @(posedge clk);
    #1 reset = 2'b00;

    @(negedge clk);
    chk("reset change_ready", int'(change_ready[0]), 1);
    chk("reset coin_valid", int'(coin_valid[0]), 0);
    chk("reset coin_value", int'(coin_value[0]), 0);
    chk("reset done", int'(done[0]), 0);
    chk("reset short", int'(short_flag[0]), 0);
    chk("reset remaining", int'(remaining[0]), 0);
    chk("reset stock_empty", int'(stock_empty[0]), 0);
    chk("reset stock_empty dut1", int'(stock_empty[1]), 0);
    @(posedge clk); #1;

    // Amount 0: straight to done, no coin
    push_done(0, 0, 0, 0);
    request(0, 0);
    @(negedge clk);
    chk("amt0 select no coin", int'(coin_valid[0]), 0);
    chk("amt0 select no done", int'(done[0]), 0);
    @(negedge clk);
    chk("amt0 done timing", int'(done[0]), 1);
    chk("amt0 busy during done", int'(change_ready[0]), 0);
    @(negedge clk);
    chk("amt0 ready after done", int'(change_ready[0]), 1);
    chk("amt0 done one cycle", int'(done[0]), 0);
    @(posedge clk); #1;

    // 87 from full stock
    coin_ack[0] = 1'b1;
    push_coin(0, 50); push_coin(0, 10); push_coin(0, 10); push_coin(0, 10);
    push_coin(0, 5);  push_coin(0, 1);  push_coin(0, 1);
    push_done(0, 0, 0, 0);
    request(0, 87);
    wait_done(0, 40);
    chk("87 stock50", int'(dut0.r_stock[0]), 7);
    chk("87 stock10", int'(dut0.r_stock[1]), 5);
    chk("87 stock5", int'(dut0.r_stock[2]), 7);
    chk("87 stock1", int'(dut0.r_stock[3]), 6);

    // Stock of 2 each: 120 then 30
    coin_ack[1] = 1'b1;
    push_coin(1, 50); push_coin(1, 50); push_coin(1, 10); push_coin(1, 10);
    push_done(1, 0, 0, 12);
    request(1, 120);
    wait_done(1, 40);
    push_coin(1, 5); push_coin(1, 5); push_coin(1, 1); push_coin(1, 1);
    push_done(1, 1, 18, 15);
    request(1, 30);
    wait_done(1, 40);
    chk("short remaining held in idle", int'(remaining[1]), 18);

    refill[1] = 1'b1;
    @(posedge clk); #1;
    refill[1] = 1'b0;
    @(negedge clk);
    chk("refill stock_empty", int'(stock_empty[1]), 0);
    @(posedge clk); #1;

    // Ack stall on 15 with ignored request/refill while busy
    coin_ack[0] = 1'b0;
    push_coin(0, 10); push_coin(0, 5);
    push_done(0, 0, 0, 0);
    request(0, 15);
    wait_valid(0, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      change_valid[0]  = (i == 1);
      refill[0]        = (i == 1);
      change_amount[0] = (i == 1) ? 8'd99 : 8'd0;
      @(negedge clk);
      chk("stall coin_valid", int'(coin_valid[0]), 1);
      chk("stall coin_value", int'(coin_value[0]), 10);
      chk("stall remaining", int'(remaining[0]), 15);
    end
    @(posedge clk); #1;
    coin_ack[0] = 1'b1;
    wait_done(0, 20);
    chk("stall stock50 no refill", int'(dut0.r_stock[0]), 7);
    chk("stall stock10", int'(dut0.r_stock[1]), 4);
    chk("stall stock5", int'(dut0.r_stock[2]), 6);

    // Reset during ISSUE
    coin_ack[0] = 1'b0;
    request(0, 50);
    wait_valid(0, 10);
    @(posedge clk); #1;
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    @(negedge clk);
    chk("midreset coin_valid", int'(coin_valid[0]), 0);
    chk("midreset change_ready", int'(change_ready[0]), 1);
    chk("midreset remaining", int'(remaining[0]), 0);
    chk("midreset done", int'(done[0]), 0);
    chk("midreset stock50", int'(dut0.r_stock[0]), 8);
    chk("midreset stock10", int'(dut0.r_stock[1]), 8);
    coin_ack[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending-machine controller. It accepts the change amount the controller computes after a sale or cancel, and pays it out one physical coin at a time to the coin-ejector mechanism. Payout is greedy largest-denomination-first, using the NT$50/10/5/1 coins, with per-denomination stock tracking. When stock cannot cover the full amount, the block completes with a shortfall flag and reports the unpaid remainder.

## Interface
Parameters:
- INIT_STOCK, 8, coins of each denomination loaded at reset/refill; must be < 2^STOCK_W
- STOCK_W, 6, width of each stock counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- change_valid  in  1  change request present
- change_amount  in  8  amount to pay out, dollars, 0..255
- change_ready  out  1  block idle, will accept request this cycle
- coin_valid  out  1  coin_value is offered to ejector
- coin_value  out  6  denomination offered: 50, 10, 5 or 1
- coin_ack  in  1  ejector has taken the offered coin
- refill  in  1  reload all stocks to INIT_STOCK
- done  out  1  one-cycle pulse, request finished
- short  out  1  valid with done; 1 = could not pay in full
- remaining  out  8  unpaid amount
- stock_empty  out  4  bit3..0 = stock of 50/10/5/1 is zero

## Operation
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE:
  - change_ready=1.
  - change_valid sampled high: latch change_amount into remaining, go SELECT.
  - refill sampled high (no request the same cycle): all stocks <= INIT_STOCK.
- SELECT:
  - remaining==0 -> DONE, short=0.
  - Otherwise pick the largest d in {50,10,5,1} with d<=remaining and stock[d]!=0. Load coin_value=d, go ISSUE.
  - If no such d -> DONE, short=1.
- ISSUE:
  - coin_valid=1; coin_value held stable.
  - On coin_ack: remaining -= coin_value, stock[d] -= 1, go SELECT.
- DONE: done=1 for exactly one cycle, short per SELECT decision, then IDLE.
- remaining holds its final value (0 or shortfall) through IDLE until the next accept.
- Arithmetic:
  - Subtraction never underflows because d<=remaining is guaranteed.
  - Stock counters never decrement below 0.
  - Everything is unsigned.
- Ignored inputs:
  - change_valid when change_ready=0: no queueing.
  - coin_ack when coin_valid=0.
  - refill outside IDLE.
- Simultaneous events: change_valid and refill in the same IDLE cycle means the request is accepted and refill is ignored.

## Timing
- Reset values:
  - state IDLE.
  - change_ready=1, coin_valid=0, coin_value=0, done=0, short=0.
  - remaining=0, stocks=INIT_STOCK, stock_empty=0.
- Reset mid-operation aborts any payout; the next cycle shows the reset values. No done pulse is produced.
- Accept on edge E0:
  - SELECT occupies the cycle after E0.
  - coin_valid rises the cycle after E1.
  - Each coin costs 2 cycles with same-cycle ack: SELECT plus ISSUE.
- done is asserted the cycle after the final SELECT; change_ready returns the cycle after done.
- Amount 0: done 2 cycles after the accept edge.
- coin_valid/coin_value are registered outputs. stock_empty and remaining are registered and reflect post-ack values the cycle after ack.

## Structure
- Package vend_pkg holds:
  - the denomination constants COIN_50/10/5/1;
  - the denomination index enum (D50, D10, D5, D1);
  - the state enum;
  - the 8-bit amount type, shared with the vending-machine controller.
- One sub-module, change_coin_select: combinational priority picker. Inputs are remaining and the four stock-nonzero bits; outputs are the chosen denomination index and a found flag.
- Four stock counters and the FSM live in change_dispenser.

## Test plan
- Reset, request amount 0 -> no coin_valid; done=1, short=0 two cycles after accept; remaining=0.
- Full stock, amount 87, ack every offer immediately -> coins 50,10,10,10,5,1,1; then done with short=0, remaining=0; stock 50/10/5/1 = 7/5/7/6.
- INIT_STOCK=2:
  - amount 120 -> 50,50,10,10, short=0, stock_empty=4'b1100.
  - Then amount 30 -> 5,5,1,1; done with short=1, remaining=18, stock_empty=4'b1111.
- Ack stall: amount 15, hold coin_ack low 5 cycles on first offer -> coin_valid=1 and coin_value=10 stable throughout; remaining stays 15; payout resumes with 5 after ack.
- Reset asserted during ISSUE -> next cycle coin_valid=0, change_ready=1, remaining=0, stocks back to INIT_STOCK; no done pulse.
- Ignored inputs while busy: change_valid and refill pulses during ISSUE -> no effect on remaining or stocks; after done, refill in IDLE restores stock_empty=4'b0000.
